// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - HI/LO multiply/divide sequencer with pipeline stall and write strobes
//
// Purpose: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX. Multiply and divide
// run as a 32-step radix-2 engine (shift-add / restoring subtract) followed by
// a sign-fix cycle and a single write cycle.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op         operation valid and opcode (0 MULT .. 5 MTLO, 6/7 no-op)
//   src_a, src_b      rs / rt operands
//   flush             cancel an in-flight operation before it commits
//   stall             combinational hold request to EX and earlier stages
//   whi, wlo          registered one-cycle HI/LO write strobes
//   hi_w, lo_w        registered HI/LO write data
//   done              registered, mul/div result written this cycle
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        whi,
  output logic        wlo,
  output logic [31:0] hi_w,
  output logic [31:0] lo_w,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_WRITE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;     // mul: {partial hi, multiplier/low}; div: [31:0] dividend -> quotient
  logic [32:0] rem_q, rem_d;     // divide partial remainder
  logic [31:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic        is_div_q, is_div_d;
  logic        neg_lo_q, neg_lo_d; // negate product / quotient
  logic        neg_hi_q, neg_hi_d; // negate remainder
  logic        whi_q, whi_d;
  logic        wlo_q, wlo_d;
  logic        done_q, done_d;
  logic [31:0] hi_w_q, hi_w_d;
  logic [31:0] lo_w_q, lo_w_d;

  // Issue-side decode
  logic        accept, is_signed, sa, sb, div_zero, div_ovf;
  logic [31:0] mag_a, mag_b;
  assign accept    = (state_q == S_IDLE) && start && !flush;
  assign is_signed = ~op[0];
  assign sa        = is_signed & src_a[31];
  assign sb        = is_signed & src_b[31];
  assign mag_a     = sa ? (~src_a + 32'd1) : src_a;
  assign mag_b     = sb ? (~src_b + 32'd1) : src_b;
  assign div_zero  = op[1] && (src_b == 32'd0);
  assign div_ovf   = (op == 3'd2) && (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);

  // One multiply step: conditionally add multiplicand to the upper half, shift right.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // One restoring divide step: bring in the next dividend bit, try the subtract.
  logic [32:0] rem_sh, rem_diff;
  logic        q_bit;
  assign rem_sh   = {rem_q[31:0], acc_q[31]};
  assign rem_diff = rem_sh - {1'b0, opnd_q};
  assign q_bit    = ~rem_diff[32];

  // Sign fix-up of the finished magnitudes
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  assign prod_fix = neg_lo_q ? (~acc_q + 64'd1) : acc_q;
  assign quo_fix  = neg_lo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix  = neg_hi_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    whi_d    = 1'b0;
    wlo_d    = 1'b0;
    done_d   = 1'b0;
    hi_w_d   = hi_w_q;
    lo_w_d   = lo_w_q;
    stall    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!op[2]) begin
            stall = 1'b1;
            if (div_zero || div_ovf) begin
              // Architectural results are known at issue; go straight to the write.
              whi_d   = 1'b1;
              wlo_d   = 1'b1;
              done_d  = 1'b1;
              hi_w_d  = div_zero ? src_a : 32'd0;
              lo_w_d  = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
              state_d = S_WRITE;
            end else begin
              opnd_d   = op[1] ? mag_b : mag_a;
              acc_d    = {32'd0, (op[1] ? mag_a : mag_b)};
              rem_d    = 33'd0;
              is_div_d = op[1];
              neg_lo_d = sa ^ sb;
              neg_hi_d = sa;
              cnt_d    = 5'd0;
              state_d  = S_CALC;
            end
          end else if (op == 3'd4) begin
            whi_d  = 1'b1;
            hi_w_d = src_a;
          end else if (op == 3'd5) begin
            wlo_d  = 1'b1;
            lo_w_d = src_a;
          end
        end
      end
      S_CALC: begin
        stall = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            rem_d = q_bit ? rem_diff : rem_sh;
            acc_d = {acc_q[63:32], acc_q[30:0], q_bit};
          end else begin
            acc_d = mul_next;
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_FIX;
        end
      end
      S_FIX: begin
        stall = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          whi_d   = 1'b1;
          wlo_d   = 1'b1;
          done_d  = 1'b1;
          hi_w_d  = is_div_q ? rem_fix : prod_fix[63:32];
          lo_w_d  = is_div_q ? quo_fix : prod_fix[31:0];
          state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      rem_q    <= 33'd0;
      opnd_q   <= 32'd0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      whi_q    <= 1'b0;
      wlo_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_w_q   <= 32'd0;
      lo_w_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      whi_q    <= whi_d;
      wlo_q    <= wlo_d;
      done_q   <= done_d;
      hi_w_q   <= hi_w_d;
      lo_w_q   <= lo_w_d;
    end
  end

  assign whi  = whi_q;
  assign wlo  = wlo_q;
  assign done = done_q;
  assign hi_w = hi_w_q;
  assign lo_w = lo_w_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - self-checking bench for hilo_muldiv_ctrl
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        stall, whi, wlo, done;
  logic [31:0] hi_w, lo_w;

  int n_checks = 0;
  int n_errors = 0;

  hilo_muldiv_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .flush (flush),
    .stall (stall),
    .whi   (whi),
    .wlo   (wlo),
    .hi_w  (hi_w),
    .lo_w  (lo_w),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural result and issue-to-write latency in cycles.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ehi, output logic [31:0] elo, output int elat);
    logic signed [31:0] sa, sb, q, r;
    logic signed [63:0] pa, pb, ps;
    logic [63:0] pu;
    sa = a; sb = b;
    elat = 34;
    case (o)
      3'd0: begin pa = sa; pb = sb; ps = pa * pb; ehi = ps[63:32]; elo = ps[31:0]; end
      3'd1: begin pu = {32'd0, a} * {32'd0, b}; ehi = pu[63:32]; elo = pu[31:0]; end
      default: begin
        if (b == 0) begin
          ehi = a; elo = 32'hFFFF_FFFF; elat = 1;
        end else if (o == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          ehi = 0; elo = 32'h8000_0000; elat = 1;
        end else if (o == 3'd2) begin
          q = sa / sb; r = sa % sb; ehi = r; elo = q;
        end else begin
          ehi = a % b; elo = a / b;
        end
      end
    endcase
  endtask

  task automatic run_muldiv(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] ehi, elo;
    int elat, n;
    logic stall_ok, quiet_ok, got_done;
    model(o, a, b, ehi, elo, elat);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1 check($sformatf("%s stall_issue", tag), stall, 1);
    stall_ok = 1; quiet_ok = 1; got_done = 0; n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done) begin got_done = 1; break; end
      if (!stall) stall_ok = 0;
      if (whi || wlo) quiet_ok = 0;
    end
    check($sformatf("%s latency", tag), got_done ? n : -1, elat);
    check($sformatf("%s stall_window", tag), stall_ok, 1);
    check($sformatf("%s no_early_strobe", tag), quiet_ok, 1);
    check($sformatf("%s hi_w", tag), hi_w, ehi);
    check($sformatf("%s lo_w", tag), lo_w, elo);
    check($sformatf("%s strobes", tag), {whi, wlo, stall}, 3'b110);
    start = 1'b0;
    @(negedge clk);
    check($sformatf("%s pulse_end", tag), {whi, wlo, done, stall}, 4'b0000);
  endtask

  task automatic run_mt(input logic [2:0] o, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = 32'h0;
    #1 check("mt stall", stall, 0);
    @(negedge clk);
    start = 1'b0;
    check("mt strobes", {whi, wlo, done, stall}, {o == 3'd4, o == 3'd5, 2'b00});
    check("mt data", (o == 3'd4) ? hi_w : lo_w, a);
    @(negedge clk);
    check("mt pulse_end", {whi, wlo}, 2'b00);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int strobes = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (whi || wlo || done) strobes++;
    end
    check(tag, strobes, 0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int sel;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; src_a = 0; src_b = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset strobes", {stall, whi, wlo, done}, 4'b0000);
    check("reset hi_w", hi_w, 0);
    check("reset lo_w", lo_w, 0);

    run_muldiv(3'd0, 32'hFFFF_FFFD, 32'd5, "mult_m3x5");
    run_muldiv(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_muldiv(3'd3, 32'd100, 32'd7, "divu_100_7");
    run_muldiv(3'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_muldiv(3'd2, 32'd9, 32'd0, "div_by_zero");
    run_muldiv(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_muldiv(3'd3, 32'hFFFF_FFFF, 32'd0, "divu_by_zero");
    run_mt(3'd5, 32'h1234_5678);

    // Flush mid-CALC: nothing written, then MTHI proceeds normally.
    @(negedge clk);
    start = 1'b1; op = 3'd2; src_a = 32'd1000; src_b = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1 check("flush stall_drop", stall, 0);
    watch_quiet("flush no_write", 40);
    run_mt(3'd4, 32'hDEAD_BEEF);

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom; rb = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 0;
      else if (sel == 1) rb = $urandom_range(1, 15);
      else if (sel == 2) rb = -32'($urandom_range(1, 15));
      else if (sel == 3) begin ro = 3'd2; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      run_muldiv(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
    end

    // Asynchronous reset during a strobe clears outputs immediately.
    @(negedge clk);
    start = 1'b1; op = 3'd4; src_a = 32'hCAFE_F00D;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1 check("async_rst outputs", {whi, wlo, done, stall}, 4'b0000);
    check("async_rst hi_w", hi_w, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-CALC: idle afterwards and no write ever appears.
    run_muldiv(3'd1, 32'h0001_0001, 32'h0000_FFFF, "pre_rst_multu");
    @(negedge clk);
    start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7;
    repeat (10) @(negedge clk);
    rst_n = 1'b0; start = 1'b0;
    #1 check("midcalc_rst outputs", {whi, wlo, done, stall}, 4'b0000);
    check("midcalc_rst data", {hi_w, lo_w}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet("midcalc_rst no_write", 40);
    run_muldiv(3'd3, 32'd100, 32'd7, "post_rst_divu");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
